// File: rtl/mac_alu_if.sv
// Bus between the read-side controller/IMEM and the mac_alu engine.
interface mac_alu_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic              start_mac;
  logic [AW-1:0]     sample_addr;
  logic [DATA_W-1:0] sample_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              busy;
  logic              mac_done;
  logic [OUT_W-1:0]  mac_result;
  logic              result_valid;
  logic              sat_flag;

  modport master (
    output start_mac, sample_data, coef_we, coef_addr, coef_wdata,
    input  sample_addr, busy, mac_done, mac_result, result_valid, sat_flag
  );

  modport slave (
    input  start_mac, sample_data, coef_we, coef_addr, coef_wdata,
    output sample_addr, busy, mac_done, mac_result, result_valid, sat_flag
  );
endinterface

// File: rtl/mac_alu.sv
// Sequential signed MAC over TAPS IMEM entries with local coefficients.
// Optional macro MAC_SAT_EN: saturate result to signed OUT_W and report sat_flag.
module mac_alu #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input logic    clk,
  input logic    reset,
  mac_alu_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;
  logic [AW-1:0]            addr_q;
  logic [OUT_W-1:0]         res_q, res_d;
  logic                     sat_q, sat_d, valid_q;
  logic                     last;

  assign last = (addr_q == AW'(TAPS - 1));
  assign prod = $signed(bus.sample_data) * coef[addr_q];
  assign acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef MAC_SAT_EN
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  logic [EXT_W-1:0]       acc_ext;
  logic [EXT_W-OUT_W:0]   hi;
  always_comb begin
    acc_ext = {{(EXT_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};
    hi      = acc_ext[EXT_W-1:OUT_W-1];
    res_d   = acc_ext[OUT_W-1:0];
    sat_d   = 1'b0;
    // Value fits only if every bit above the OUT_W sign bit copies it.
    if (!(&hi || ~|hi)) begin
      sat_d = 1'b1;
      res_d = acc_ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign res_d = OUT_W'(acc_d);
  assign sat_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.busy     = 1'b0;
    bus.mac_done = 1'b0;
    case (state_q)
      IDLE: if (bus.start_mac) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.mac_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result is captured on the edge that enters DONE so it is visible
  // in the same cycle as the mac_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      addr_q  <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_wdata;
          if (bus.start_mac) begin
            acc_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last) begin
            res_q   <= res_d;
            sat_q   <= sat_d;
            valid_q <= 1'b1;
            addr_q  <= '0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        default: addr_q <= '0;
      endcase
    end
  end

  assign bus.sample_addr  = addr_q;
  assign bus.mac_result   = res_q;
  assign bus.sat_flag     = sat_q;
  assign bus.result_valid = valid_q;
endmodule
